// File: rtl/keypad_cursor_ctrl_if.sv
// keypad_cursor_ctrl_if: key handshake between the keypad controller and the calculator logic.
interface keypad_cursor_ctrl_if;
    logic       key_valid;
    logic       key_ready;
    logic       key_drop;
    logic [7:0] key_code;
    modport master (output key_valid, key_code, key_drop, input key_ready);
    modport slave  (input key_valid, key_code, key_drop, output key_ready);
endinterface

// File: rtl/keypad_cursor_ctrl.sv
// keypad_cursor_ctrl: debounced five-button cursor control with wrap, auto-repeat and key emission.
module keypad_cursor_ctrl #(
    parameter int GRID_COLS    = 3,
    parameter int GRID_ROWS    = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                        clk_in,
    input  logic                        sys_rst_n,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_sel,
    output logic [3:0]                  cursor_x,
    output logic [3:0]                  cursor_y,
    keypad_cursor_ctrl_if.master        key_if
);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [7:0] KEY_LUT [16] = '{"1", "2", "3", "4", "5", "6", "7", "8", "9", "+", "0", "=",
                                            8'h00, 8'h00, 8'h00, 8'h00};

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_e;

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [4:0]    btn_raw, sync1_q, sync2_q, stable_q, stable_d, stable_prev_q, press;
    logic [DW-1:0] db_cnt_q [5];
    logic [DW-1:0] db_cnt_d [5];
    rstate_e       state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    dir_q, dir_d, win_idx;
    logic [3:0]    dir_ev, win;
    logic          rep_ev, win_press, sel_ev, accept, in_range;
    logic [3:0]    cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d, idx;
    logic          key_valid_q, key_valid_d, key_drop_q, key_drop_d;
    logic [7:0]    key_code_q, key_code_d, key_map;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge clk_in or negedge sys_rst_n)
        if (!sys_rst_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];

    assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            db_cnt_d[i] = (sync2_q[i] == stable_q[i] || db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) ? '0 : db_cnt_q[i] + 1'b1;
            stable_d[i] = (sync2_q[i] != stable_q[i] && db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) ? sync2_q[i] : stable_q[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            db_cnt_q      <= '{default: '0};
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end

    assign press = stable_q & ~stable_prev_q;

    // Bit 0 is up, so the lowest set bit is the highest-priority direction.
    assign dir_ev    = press[3:0] | (rep_ev ? 4'b0001 << dir_q : 4'b0000);
    assign win       = dir_ev & (~dir_ev + 4'd1);
    assign win_press = |(win & press[3:0]);
    assign win_idx   = win[1] ? 2'd1 : win[2] ? 2'd2 : win[3] ? 2'd3 : 2'd0;

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            state_q <= R_IDLE;
            rcnt_q  <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            dir_q   <= dir_d;
        end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        dir_d   = dir_q;
        if (win_press) begin
            state_d = R_DELAY;
            rcnt_d  = RW'(REPEAT_DLY - 1);
            dir_d   = win_idx;
        end else if (state_q != R_IDLE && !stable_q[dir_q]) begin
            state_d = R_IDLE;
        end else if (state_q != R_IDLE) begin
            state_d = rcnt_q == '0 ? R_REPEAT : state_q;
            rcnt_d  = rcnt_q == '0 ? RW'(REPEAT_RATE - 1) : rcnt_q - 1'b1;
        end
    end

    assign rep_ev = state_q != R_IDLE && rcnt_q == '0 && stable_q[dir_q];

    always_comb begin
        cursor_y_d = win[0] ? (cursor_y_q == '0 ? 4'(GRID_ROWS - 1) : cursor_y_q - 4'd1)
                   : win[1] ? (cursor_y_q == 4'(GRID_ROWS - 1) ? '0 : cursor_y_q + 4'd1)
                   : cursor_y_q;
        cursor_x_d = win[2] ? (cursor_x_q == '0 ? 4'(GRID_COLS - 1) : cursor_x_q - 4'd1)
                   : win[3] ? (cursor_x_q == 4'(GRID_COLS - 1) ? '0 : cursor_x_q + 4'd1)
                   : cursor_x_q;
    end

    assign in_range = cursor_x_q < 4'(GRID_COLS) && cursor_y_q < 4'(GRID_ROWS) && cursor_x_q < 4'd3 && cursor_y_q < 4'd4;
    assign idx      = cursor_y_q * 4'd3 + cursor_x_q;
    assign key_map  = in_range ? KEY_LUT[idx] : 8'h00;

    // Select samples the pre-move cursor; a press while the slot is held is dropped.
    assign sel_ev      = press[4];
    assign accept      = !key_valid_q || key_if.key_ready;
    assign key_valid_d = (sel_ev && accept) || (key_valid_q && !key_if.key_ready);
    assign key_code_d  = (sel_ev && accept) ? key_map : key_code_q;
    assign key_drop_d  = sel_ev && !accept;

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            cursor_x_q  <= '0;
            cursor_y_q  <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_drop_q  <= 1'b0;
        end else begin
            cursor_x_q  <= cursor_x_d;
            cursor_y_q  <= cursor_y_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_drop_q  <= key_drop_d;
        end

    assign cursor_x         = cursor_x_q;
    assign cursor_y         = cursor_y_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_code  = key_code_q;
    assign key_if.key_drop  = key_drop_q;
endmodule

// File: tb/tb_keypad_cursor_ctrl.sv
// tb_keypad_cursor_ctrl: directed checks of debounce, wrap, auto-repeat, select handshake and reset.
module tb_keypad_cursor_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic [3:0] cursor_x, cursor_y;
    int         n_pass = 0;
    int         n_total = 0;

    keypad_cursor_ctrl_if kif ();

    keypad_cursor_ctrl #(
        .GRID_COLS(3), .GRID_ROWS(4), .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_RATE(8)
    ) dut (
        .clk_in(clk), .sys_rst_n(rst_n),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_sel(btn[4]),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .key_if(kif)
    );

    always #5 clk = ~clk;

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Hold a button 10 cycles (below the repeat delay) then let the release settle.
    task automatic press(int b);
        btn[b] = 1'b1;
        step(10);
        btn[b] = 1'b0;
        step(12);
    endtask

    initial begin
        kif.key_ready = 1'b0;
        step(3);
        chk("rst_x", cursor_x, 0);
        chk("rst_y", cursor_y, 0);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 8'h00);
        chk("rst_drop", kif.key_drop, 0);
        rst_n = 1'b1;
        step(4);

        btn[3] = 1'b1;
        step(6);
        chk("right_not_yet", cursor_x, 0);
        step(1);
        chk("right_at_7", cursor_x, 1);
        step(3);
        btn[3] = 1'b0;
        step(12);
        chk("right_single_move", cursor_x, 1);
        btn[2] = 1'b1;
        step(1);
        btn[2] = 1'b0;
        step(12);
        chk("glitch1_ignored", cursor_x, 1);
        btn[2] = 1'b1;
        step(3);
        btn[2] = 1'b0;
        step(12);
        chk("glitch3_ignored", cursor_x, 1);

        press(0);
        chk("up_wrap_y", cursor_y, 3);
        press(3);
        chk("right_x2", cursor_x, 2);
        press(3);
        chk("right_wrap_x", cursor_x, 0);
        press(2);
        chk("left_wrap_x", cursor_x, 2);
        press(1);
        chk("down_wrap_y", cursor_y, 0);

        btn[1] = 1'b1;
        for (int s = 1; s <= 70; s++) begin
            step(1);
            if (s == 48) btn[1] = 1'b0;
            case (s)
                6:  chk("rep_pre", cursor_y, 0);
                7:  chk("rep_press", cursor_y, 1);
                26: chk("rep_before_dly", cursor_y, 1);
                27: chk("rep_first", cursor_y, 2);
                34: chk("rep_before_rate", cursor_y, 2);
                35: chk("rep_second", cursor_y, 3);
                43: chk("rep_third_wrap", cursor_y, 0);
                51: chk("rep_fourth", cursor_y, 1);
                70: chk("rep_stops", cursor_y, 1);
                default: ;
            endcase
        end

        press(1);
        press(1);
        chk("at_row3", cursor_y, 3);
        kif.key_ready = 1'b1;
        btn[4] = 1'b1;
        step(6);
        chk("sel_valid_pre", kif.key_valid, 0);
        step(1);
        chk("sel_valid", kif.key_valid, 1);
        chk("sel_code_eq", kif.key_code, 8'h3D);
        step(1);
        chk("sel_valid_1cyc", kif.key_valid, 0);
        step(2);
        btn[4] = 1'b0;
        step(12);

        kif.key_ready = 1'b0;
        press(2);
        press(0);
        press(0);
        chk("at_1_1", {cursor_y, cursor_x}, 8'h11);
        press(4);
        chk("hold_valid", kif.key_valid, 1);
        chk("hold_code5", kif.key_code, 8'h35);
        press(2);
        press(0);
        chk("at_0_0", {cursor_y, cursor_x}, 8'h00);
        btn[4] = 1'b1;
        step(6);
        chk("drop_pre", kif.key_drop, 0);
        step(1);
        chk("drop_pulse", kif.key_drop, 1);
        chk("drop_keeps_code", kif.key_code, 8'h35);
        step(1);
        chk("drop_1cyc", kif.key_drop, 0);
        step(2);
        btn[4] = 1'b0;
        step(12);
        chk("drop_still_valid", kif.key_valid, 1);
        chk("drop_still_code", kif.key_code, 8'h35);
        kif.key_ready = 1'b1;
        step(1);
        chk("xfer_clears", kif.key_valid, 0);

        kif.key_ready = 1'b0;
        press(2);
        press(1);
        chk("at_2_1", {cursor_y, cursor_x}, 8'h12);
        press(4);
        chk("pend_valid", kif.key_valid, 1);
        chk("pend_code6", kif.key_code, 8'h36);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", cursor_x, 0);
        chk("arst_y", cursor_y, 0);
        chk("arst_valid", kif.key_valid, 0);
        chk("arst_code", kif.key_code, 8'h00);
        chk("arst_drop", kif.key_drop, 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("post_rst_valid", kif.key_valid, 0);
        chk("post_rst_xy", {cursor_y, cursor_x}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
